sort4_merge2: RTL and testbench

- Streaming merger directly downstream of the 4-input sorting network.
- Accepts two consecutive ascending-sorted 4-word blocks (A, then B) over a valid/ready handshake.
- Emits all 8 words one per transfer in ascending unsigned order, producing sorted runs of 8 for the next merge level.
- Single clock domain; registered buffers; combinational output mux from registered state.

---
 rtl/sort4_merge2_if.sv | 22 ++
 rtl/sort4_merge2.sv | 128 ++++++++++++
 tb/tb_sort4_merge2.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sort4_merge2_if.sv
// Handshake bundle for the 4+4 streaming merger: block input and word output.
interface sort4_merge2_if #(
    parameter int W = 32
) ();
    logic [4*W-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/sort4_merge2.sv
// Merges two ascending 4-word blocks (A then B) into one ascending 8-word run.
// Optional sortedness checker enabled by macro SORT4_MERGE2_CHECK_EN (adds sort_err).
//
// state  | meaning
// LOAD_A | waiting for first block, latches it into buffer A
// LOAD_B | waiting for second block, latches it into buffer B
// MERGE  | emitting 8 merged words, one per output handshake
module sort4_merge2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    sort4_merge2_if.slave bus
`ifdef SORT4_MERGE2_CHECK_EN
    ,
    output logic         sort_err
`endif
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        MERGE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q [4];
    logic [W-1:0]   b_q [4];
    logic [2:0]     ia_q, ia_d;
    logic [2:0]     ib_q, ib_d;

    logic [W-1:0]   a_head;
    logic [W-1:0]   b_head;
    logic           take_a;
    logic           is_last;
    logic           in_hs;
    logic           out_hs;
    logic           in_ready_int;
    logic           out_valid_int;

    // Exhausted index is 4, whose low bits alias lane 0; the select rule never uses that read.
    assign a_head  = a_q[ia_q[1:0]];
    assign b_head  = b_q[ib_q[1:0]];
    assign take_a  = (ib_q == 3'd4) || ((ia_q != 3'd4) && (a_head <= b_head));
    assign is_last = (({1'b0, ia_q} + {1'b0, ib_q}) == 4'd7);

    assign in_ready_int  = !rst && ((state_q == LOAD_A) || (state_q == LOAD_B));
    assign out_valid_int = !rst && (state_q == MERGE);
    assign in_hs         = in_ready_int && bus.in_valid;
    assign out_hs        = out_valid_int && bus.out_ready;

    always_comb begin
        bus.in_ready  = in_ready_int;
        bus.out_valid = out_valid_int;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        if (out_valid_int) begin
            bus.out_data = take_a ? a_head : b_head;
            bus.out_last = is_last;
        end
    end

    always_comb begin
        state_d = state_q;
        ia_d    = ia_q;
        ib_d    = ib_q;
        case (state_q)
            LOAD_A: begin
                if (in_hs) state_d = LOAD_B;
            end
            LOAD_B: begin
                if (in_hs) begin
                    state_d = MERGE;
                    ia_d    = 3'd0;
                    ib_d    = 3'd0;
                end
            end
            MERGE: begin
                if (out_hs) begin
                    if (take_a) ia_d = ia_q + 3'd1;
                    else        ib_d = ib_q + 3'd1;
                    if (is_last) state_d = LOAD_A;
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_A;
            ia_q    <= 3'd0;
            ib_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            ia_q    <= ia_d;
            ib_q    <= ib_d;
        end
    end

    // Buffers carry no reset; they are always rewritten before MERGE reads them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (in_hs && (state_q == LOAD_A)) a_q[i] <= bus.in_data[i*W +: W];
            if (in_hs && (state_q == LOAD_B)) b_q[i] <= bus.in_data[i*W +: W];
        end
    end

`ifdef SORT4_MERGE2_CHECK_EN
    logic sort_err_q;
    logic unsorted;

    always_comb begin
        unsorted = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.in_data[i*W +: W] > bus.in_data[(i+1)*W +: W]) unsorted = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                      sort_err_q <= 1'b0;
        else if (in_hs && unsorted)   sort_err_q <= 1'b1;
    end

    assign sort_err = sort_err_q;
`endif

endmodule

// File: tb/tb_sort4_merge2.sv
// Directed bench for sort4_merge2 with a scoreboard queue of expected merged words.
module tb_sort4_merge2;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [W-1:0] sb [$];
    int   cyc;

    sort4_merge2_if #(.W(W)) bus ();

`ifdef SORT4_MERGE2_CHECK_EN
    logic sort_err;
    sort4_merge2 #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus), .sort_err(sort_err));
`else
    sort4_merge2 #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*W-1:0] pack(input logic [W-1:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_sorted(input logic [4*W-1:0] a, input logic [4*W-1:0] b);
        logic [W-1:0] v [8];
        logic [W-1:0] t;
        for (int i = 0; i < 4; i++) begin
            v[i]   = a[i*W +: W];
            v[i+4] = b[i*W +: W];
        end
        for (int i = 1; i < 8; i++) begin
            for (int j = i; j > 0; j--) begin
                if (v[j-1] > v[j]) begin
                    t = v[j]; v[j] = v[j-1]; v[j-1] = t;
                end
            end
        end
        for (int i = 0; i < 8; i++) sb.push_back(v[i]);
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        check(tag, {31'd0, bus.in_ready}, 32'd1);
        check({tag, "_outv"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic send_pair(input logic [4*W-1:0] a, input logic [4*W-1:0] b);
        bus.in_data  = a;
        bus.in_valid = 1'b1;
        wait_ready("a_ready");
        tick();
        bus.in_data = b;
        wait_ready("b_ready");
        tick();
        bus.in_valid = 1'b0;
        check("first_valid", {31'd0, bus.out_valid}, 32'd1);
        check("in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    endtask

    task automatic collect(input int n, input logic [15:0] pat, output int cycles);
        int hs = 0;
        int lasts = 0;
        bit stalled = 0;
        logic [W-1:0] pd = '0;
        logic pl = 1'b0;
        logic [W-1:0] exp;
        cycles = 0;
        while (hs < n && cycles < 60) begin
            bus.out_ready = (cycles < 16) ? pat[cycles] : 1'b1;
            if (stalled) begin
                check("stall_data", bus.out_data, pd);
                check("stall_last", {31'd0, bus.out_last}, {31'd0, pl});
            end
            stalled = 0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    tests++;
                    assert (sb.size() != 0) else begin
                        fails++;
                        $error("FAIL sb_underflow observed=%0h expected=none", bus.out_data);
                    end
                    exp = (sb.size() != 0) ? sb.pop_front() : '0;
                    check("data", bus.out_data, exp);
                    check("last", {31'd0, bus.out_last}, (hs == 7) ? 32'd1 : 32'd0);
                    if (bus.out_last) lasts++;
                    hs++;
                end else begin
                    stalled = 1;
                    pd = bus.out_data;
                    pl = bus.out_last;
                end
            end
            tick();
            cycles++;
        end
        bus.out_ready = 1'b0;
        check("hs_count", hs, n);
        if (n == 8) check("last_count", lasts, 1);
    endtask

    initial begin
        logic [4*W-1:0] a1, b1;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
`ifdef SORT4_MERGE2_CHECK_EN
        check("rst_sort_err", {31'd0, sort_err}, 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);

        // Interleaved blocks at full throughput
        a1 = pack(1, 3, 5, 7);
        b1 = pack(2, 4, 6, 8);
        push_sorted(a1, b1);
        send_pair(a1, b1);
        collect(8, 16'hFFFF, cyc);
        check("consec_cycles", cyc, 8);
        check("in_ready_after", {31'd0, bus.in_ready}, 32'd1);

        // B exhausted first, then A exhausted first
        push_sorted(pack(10, 20, 30, 40), pack(1, 2, 3, 4));
        send_pair(pack(10, 20, 30, 40), pack(1, 2, 3, 4));
        collect(8, 16'hFFFF, cyc);
        push_sorted(pack(1, 2, 3, 4), pack(10, 20, 30, 40));
        send_pair(pack(1, 2, 3, 4), pack(10, 20, 30, 40));
        collect(8, 16'hFFFF, cyc);

        // Unsigned comparison near the top of range
        push_sorted(pack(0, 1, 2, 32'hFFFFFFFF), pack(0, 32'h80000000, 32'h80000001, 32'hFFFFFFFE));
        send_pair(pack(0, 1, 2, 32'hFFFFFFFF), pack(0, 32'h80000000, 32'h80000001, 32'hFFFFFFFE));
        collect(8, 16'hFFFF, cyc);

        // Backpressure pattern 1,0,0,1,0,1,1,1,...
        push_sorted(a1, b1);
        send_pair(a1, b1);
        collect(8, 16'hFFE9, cyc);
        check("bp_cycles", cyc, 11);

        // Reset after the 3rd output handshake
        push_sorted(a1, b1);
        send_pair(a1, b1);
        collect(3, 16'hFFFF, cyc);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_out_data", bus.out_data, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("postrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("postrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        sb.delete();
        @(negedge clk);
        push_sorted(pack(9, 9, 9, 9), pack(9, 9, 9, 9));
        send_pair(pack(9, 9, 9, 9), pack(9, 9, 9, 9));
        collect(8, 16'hFFFF, cyc);

        // Unsorted A: selection rule takes A lanes in place while each is <= 5
        for (int i = 0; i < 8; i++) sb.push_back((i < 4) ? (4 - i) : (i + 1));
        send_pair(pack(4, 3, 2, 1), pack(5, 6, 7, 8));
`ifdef SORT4_MERGE2_CHECK_EN
        check("sort_err_set", {31'd0, sort_err}, 32'd1);
`endif
        collect(8, 16'hFFFF, cyc);
        push_sorted(a1, b1);
        send_pair(a1, b1);
        collect(8, 16'hFFFF, cyc);
`ifdef SORT4_MERGE2_CHECK_EN
        check("sort_err_sticky", {31'd0, sort_err}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sort_err_cleared", {31'd0, sort_err}, 32'd0);
`endif

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
